// File: rtl/chan_sel_ctrl.sv
// Registered channel-select controller: direct one-hot decode with a valid/ready request
// and ack release, or an autonomous scan over the enabled channels with a programmable dwell.
module chan_sel_ctrl #(
  parameter int unsigned N       = 2,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                c_vld,
  input  logic [N-1:0]        c,
  output logic                c_rdy,
  input  logic [(1<<N)-1:0]   en_mask,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [(1<<N)-1:0]   s,
  output logic                s_vld,
  input  logic                s_ack,
  output logic [N-1:0]        cur_ch,
  output logic                err
);

  localparam int unsigned NCH = 1 << N;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NCH-1:0]     r_s, w_s_nxt;
  logic               r_s_vld, w_s_vld_nxt;
  logic [N-1:0]       r_cur_ch, w_cur_ch_nxt;
  logic               r_err, w_err_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;

  logic [N-1:0]       w_first_ch;
  logic [N-1:0]       w_start;
  logic [2*NCH-1:0]   w_dbl;
  logic [NCH-1:0]     w_rot;
  logic [N-1:0]       w_rot_idx;
  logic [N-1:0]       w_adv_ch;

  // Search for the next enabled channel starts just above cur_ch (wraps in N bits).
  assign w_start  = r_cur_ch + N'(1);
  assign w_dbl    = {en_mask, en_mask};
  assign w_rot    = w_dbl[w_start +: NCH];
  assign w_adv_ch = w_start + w_rot_idx;

  always_comb begin : first_enc
    w_first_ch = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (en_mask[i]) w_first_ch = N'(i);
    end
  end

  always_comb begin : rot_enc
    w_rot_idx = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rot_idx = N'(i);
    end
  end

  assign c_rdy = (r_state == ST_IDLE) & ~mode;

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_s_vld  <= 1'b0;
      r_cur_ch <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_s_vld  <= w_s_vld_nxt;
      r_cur_ch <= w_cur_ch_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin : next_state
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_s_vld_nxt  = r_s_vld;
    w_cur_ch_nxt = r_cur_ch;
    w_err_nxt    = 1'b0;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (mode) begin
          if (|en_mask) begin
            w_state_nxt  = ST_SCAN;
            w_s_nxt      = NCH'(1) << w_first_ch;
            w_s_vld_nxt  = 1'b1;
            w_cur_ch_nxt = w_first_ch;
            w_cnt_nxt    = dwell;
          end
        end else if (c_vld) begin
          if (en_mask[c]) begin
            w_state_nxt  = ST_HOLD;
            w_s_nxt      = NCH'(1) << c;
            w_s_vld_nxt  = 1'b1;
            w_cur_ch_nxt = c;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (s_ack) begin
          w_state_nxt = ST_IDLE;
          w_s_nxt     = '0;
          w_s_vld_nxt = 1'b0;
        end
      end

      ST_SCAN: begin
        // Exit wins over the dwell counter; a masked current channel still finishes its dwell.
        if (!mode || (en_mask == '0)) begin
          w_state_nxt = ST_IDLE;
          w_s_nxt     = '0;
          w_s_vld_nxt = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else begin
          w_s_nxt      = NCH'(1) << w_adv_ch;
          w_cur_ch_nxt = w_adv_ch;
          w_cnt_nxt    = dwell;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = '0;
        w_s_vld_nxt = 1'b0;
      end
    endcase
  end

  assign s      = r_s;
  assign s_vld  = r_s_vld;
  assign cur_ch = r_cur_ch;
  assign err    = r_err;

endmodule

// File: tb/tb_chan_sel_ctrl.sv
// Bench for chan_sel_ctrl: directed scenarios then random traffic, all outputs compared
// every cycle against a cycle-count reference model of direct/scan behaviour.
module tb_chan_sel_ctrl;

  localparam int unsigned N   = 2;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mode = 1'b0;
  logic           c_vld = 1'b0;
  logic [N-1:0]   c = '0;
  logic           c_rdy;
  logic [NCH-1:0] en_mask = '1;
  logic [DW-1:0]  dwell = '0;
  logic [NCH-1:0] s;
  logic           s_vld;
  logic           s_ack = 1'b0;
  logic [N-1:0]   cur_ch;
  logic           err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which activity is in progress, the channel, and time spent on it.
  bit m_held = 0;
  bit m_scan = 0;
  bit m_err  = 0;
  int m_ch   = 0;
  int m_spent = 0;
  int m_len   = 1;

  chan_sel_ctrl #(.N(N), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .c_vld(c_vld), .c(c), .c_rdy(c_rdy),
    .en_mask(en_mask), .dwell(dwell), .s(s), .s_vld(s_vld), .s_ack(s_ack),
    .cur_ch(cur_ch), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_en(input int from, input logic [NCH-1:0] m);
    for (int k = 1; k <= int'(NCH); k++) begin
      if (m[(from + k) % int'(NCH)]) return (from + k) % int'(NCH);
    end
    return from;
  endfunction

  task automatic check_all();
    logic [NCH-1:0] es;
    bit active;
    active = m_held || m_scan;
    es = active ? (NCH'(1) << m_ch) : '0;
    chk("s", 32'(s), 32'(es));
    chk("s_vld", 32'(s_vld), 32'(active));
    chk("cur_ch", 32'(cur_ch), 32'(m_ch));
    chk("err", 32'(err), 32'(m_err));
    chk("c_rdy", 32'(c_rdy), 32'(!active && !mode));
    chk("onehot", 32'($onehot0(s) && ((s != '0) == s_vld)), 32'(1));
  endtask

  task automatic model_edge();
    m_err = 0;
    if (m_held) begin
      if (s_ack) m_held = 0;
    end else if (m_scan) begin
      if (!mode || en_mask == '0) begin
        m_scan = 0;
      end else begin
        m_spent++;
        if (m_spent == m_len) begin
          m_ch    = next_en(m_ch, en_mask);
          m_spent = 0;
          m_len   = int'(dwell) + 1;
        end
      end
    end else if (mode) begin
      if (en_mask != '0) begin
        m_scan  = 1;
        m_ch    = next_en(int'(NCH) - 1, en_mask);
        m_spent = 0;
        m_len   = int'(dwell) + 1;
      end
    end else if (c_vld) begin
      if (en_mask[c]) begin
        m_held = 1;
        m_ch   = int'(c);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at posedge+1; asserts reset between edges, holds it across one edge, releases mid-cycle.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    m_held = 0; m_scan = 0; m_err = 0; m_ch = 0;
    check_all();
    chk("rst_async_s", 32'(s), 32'(0));
    chk("rst_async_cur_ch", 32'(cur_ch), 32'(0));
    @(posedge clk);
    #1;
    check_all();
    #3;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    check_all();
    chk("rst_s", 32'(s), 32'(0));
    chk("rst_s_vld", 32'(s_vld), 32'(0));
    rst = 1'b1;

    // Direct request, hold, ack
    c = 2'd2; c_vld = 1'b1;
    step();
    c_vld = 1'b0;
    chk("t1_s", 32'(s), 32'h4);
    chk("t1_cur_ch", 32'(cur_ch), 32'd2);
    chk("t1_c_rdy", 32'(c_rdy), 32'd0);
    c = 2'd0; en_mask = 4'b0001;
    steps(5);
    chk("t1_held", 32'(s), 32'h4);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    chk("t1_rel_s", 32'(s), 32'h0);
    chk("t1_rel_c_rdy", 32'(c_rdy), 32'd1);

    // Masked request then a legal one
    en_mask = 4'b1011; c = 2'd2; c_vld = 1'b1;
    step();
    c_vld = 1'b0;
    chk("t2_err", 32'(err), 32'd1);
    step();
    chk("t2_err_pulse", 32'(err), 32'd0);
    c = 2'd3; c_vld = 1'b1;
    step();
    c_vld = 1'b0;
    chk("t2_s", 32'(s), 32'h8);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;

    // Scan with dwell, dwell change applies at next channel
    mode = 1'b1; en_mask = 4'b1101; dwell = 8'd2;
    step();
    chk("t3_first", 32'(s), 32'h1);
    steps(2);
    chk("t3_dwell_end", 32'(s), 32'h1);
    step();
    chk("t3_adv", 32'(s), 32'h4);
    dwell = 8'd0;
    steps(2);
    chk("t3_latched_dwell", 32'(s), 32'h4);
    step();
    chk("t3_adv2", 32'(s), 32'h8);
    step();
    chk("t3_wrap", 32'(s), 32'h1);
    mode = 1'b0;
    step();

    // Single enabled channel, then mask cleared
    mode = 1'b1; en_mask = 4'b0010; dwell = 8'd1;
    steps(6);
    chk("t4_single", 32'(s), 32'h2);
    chk("t4_cur_ch", 32'(cur_ch), 32'd1);
    en_mask = 4'b0000;
    step();
    chk("t4_exit", 32'(s_vld), 32'd0);
    mode = 1'b0; en_mask = 4'hF;
    step();

    // Mode has priority over a pending request
    mode = 1'b1; c_vld = 1'b1; c = 2'd0; dwell = 8'd3;
    #1;
    chk("t5_c_rdy", 32'(c_rdy), 32'd0);
    step();
    chk("t5_scan", 32'(s_vld), 32'd1);
    chk("t5_no_err", 32'(err), 32'd0);
    c_vld = 1'b0;
    step();
    mode = 1'b0;
    step();
    chk("t5_exit_s", 32'(s), 32'h0);
    chk("t5_exit_c_rdy", 32'(c_rdy), 32'd1);

    // Async reset in HOLD and in SCAN
    c = 2'd0; c_vld = 1'b1;
    step();
    c_vld = 1'b0;
    step();
    async_reset();
    mode = 1'b1; en_mask = 4'hF;
    steps(2);
    async_reset();
    mode = 1'b0; c = 2'd1; c_vld = 1'b1;
    step();
    c_vld = 1'b0;
    chk("t6_s", 32'(s), 32'h2);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      if (k % 500 == 250) async_reset();
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) en_mask = NCH'($urandom);
      dwell = DW'($urandom_range(0, 3));
      c     = N'($urandom);
      c_vld = ($urandom_range(0, 2) == 0);
      s_ack = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chan_sel_ctrl.md
Name: chan_sel_ctrl

Overview:
Registered, parametrised channel-select controller: a successor to the combinational channel-number-to-one-hot decoder.
- Direct mode: a requested channel number is accepted over a valid/ready handshake, checked against an enable mask, and driven as a held one-hot select until acknowledged.
- Scan mode: the block cycles through the enabled channels autonomously, dwelling a programmable number of cycles on each.
- Sits between the control/args path and per-channel datapath enables.

Parameters:
N, 2, channel-number width; channel count is 2**N (N >= 1)
DWELL_W, 8, width of dwell-count input and internal dwell counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
mode  input  1  0 = direct decode, 1 = auto scan
c_vld  input  1  channel request valid (direct mode)
c  input  N  requested channel number
c_rdy  output  1  request accepted when c_vld & c_rdy
en_mask  input  2**N  per-channel enable; bit i enables channel i
dwell  input  DWELL_W  scan dwell; each channel is held dwell+1 cycles
s  output  2**N  registered one-hot channel select (all-zero when idle)
s_vld  output  1  s carries a valid selection
s_ack  input  1  release of a held direct-mode selection
cur_ch  output  N  binary index of the channel currently selected
err  output  1  one-cycle pulse: accepted request targeted a masked channel

Behaviour:
- Reset (rst=0, async): s=0, s_vld=0, cur_ch=0, err=0, dwell counter=0, state=IDLE. On deassertion, first active edge evaluates IDLE.
- c_rdy is combinational: c_rdy = (state==IDLE) & ~mode. Outside IDLE it is 0.
- States: IDLE, HOLD, SCAN.
- IDLE, mode=0:
  - Handshake with en_mask[c]=1: next cycle s=1<<c, s_vld=1, cur_ch=c, state→HOLD. Latency 1 cycle.
  - Handshake with en_mask[c]=0: next cycle err=1 for exactly one cycle; s and s_vld stay 0; state stays IDLE.
- IDLE, mode=1:
  - en_mask≠0: next cycle enter SCAN on the lowest enabled index (search starts at 0). s=onehot, s_vld=1, cur_ch=index, dwell counter loaded with dwell.
  - en_mask=0: stay IDLE with outputs 0.
  - mode has priority over c_vld: no handshake occurs while mode=1.
- HOLD:
  - s, s_vld and cur_ch are held; changes to en_mask, c and mode are ignored.
  - s_ack=1: next cycle s=0, s_vld=0, state→IDLE. cur_ch keeps its last value.
  - s_ack is ignored in every state other than HOLD.
- SCAN:
  - Counter nonzero: decrement.
  - Counter 0: advance to the next enabled channel above cur_ch, wrapping modulo 2**N, and reload the counter from dwell. dwell is sampled only at channel entry.
  - Single enabled channel: it is reselected, so s stays continuously high.
  - Advance search uses en_mask at the advance cycle.
  - en_mask becomes 0, or mode becomes 0: next cycle s=0, s_vld=0, state→IDLE, regardless of counter. The en_mask=0 exit is checked every cycle.
  - Currently selected channel masked mid-dwell but en_mask≠0: finish the dwell, then advance.
- s is always either all-zero or exactly one-hot, and s≠0 iff s_vld=1.
- Reset asserted mid-operation in any state: immediate return to reset values; no err pulse.
- Next-enabled search is a combinational priority scan over 2**N bits (rotate by cur_ch+1, priority-encode, un-rotate). No multi-cycle search.

Test Plan:
1. N=2, en_mask=4'b1111, mode=0, c=2 with c_vld for 1 cycle → next cycle s=4'b0100, s_vld=1, cur_ch=2, c_rdy=0; hold 5 cycles, then s_ack → following cycle s=0, c_rdy=1.
2. en_mask=4'b1011, c=2 requested → err high exactly 1 cycle, s=0, state stays IDLE; a following request c=3 → s=4'b1000.
3. mode=1, en_mask=4'b1101, dwell=2 → s sequence 0001×3, 0100×3, 1000×3, 0001… (wrap). Changing dwell to 0 mid-dwell takes effect at the next channel only.
4. Scan with en_mask=4'b0010 → s=4'b0010 held continuously, cur_ch=1. Then en_mask=0 → next cycle s=0, s_vld=0, IDLE.
5. mode=1 with c_vld=1, c=0 simultaneously → c_rdy=0, no err, SCAN entered. Then mode=0 mid-dwell → next cycle s=0, c_rdy=1.
6. rst pulled low in HOLD and in SCAN (asynchronously, between edges) → s, s_vld, cur_ch, err go 0 immediately. After release, direct request c=1 → s=4'b0010 with 1-cycle latency.
